moore_seq_ctrl: RTL and testbench

Sequencer for the two-state Moore detector (ain[1:0] in, aout out, sync reset). It holds a small programmable symbol pattern and, on start, clears the detector, streams the pattern into ain for a programmed number of loops, and samples aout after every symbol. Results are the count of symbols that left aout=1 and the final aout, reported with a done pulse. Sits between the config/control bus and one detector instance.

---
 rtl/moore_seq_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_moore_seq_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/moore_seq_ctrl.sv
// -----------------------------------------------------------------------------
// moore_seq_ctrl
// Sequencer for a two-state Moore detector. Holds a small programmable symbol
// pattern. On a valid start it clears the detector, streams the pattern into
// the detector's ain for a programmed number of loops, and samples the
// detector's aout after every symbol. It reports the number of symbols that
// left aout=1 (saturating) and the final aout, followed by a one-cycle done
// pulse.
//
// Ports:
//   clk        in   clock, all logic on the rising edge
//   reset      in   synchronous active-high reset (also resets the detector)
//   cfg_we     in   pattern write strobe (honoured only in IDLE/DONE)
//   cfg_addr   in   pattern write address [ADDR_W]
//   cfg_data   in   symbol to write [2]
//   start      in   run request, sampled in IDLE only
//   len        in   symbols per loop [ADDR_W+1], valid 1..DEPTH
//   loops      in   loop count [LOOP_W], valid >= 1
//   fsm_reset  out  detector reset
//   fsm_ain    out  detector ain [2]
//   fsm_aout   in   detector aout
//   busy       out  run in progress (CLR, RUN, DRAIN)
//   done       out  one-cycle completion pulse
//   err        out  one-cycle pulse after an invalid start
//   ones_count out  symbols after which aout=1 [CNT_W], saturating
//   final_out  out  aout after the last symbol
// -----------------------------------------------------------------------------
module moore_seq_ctrl #(
   parameter int DEPTH  = 8,
   parameter int LOOP_W = 4,
   parameter int CNT_W  = 8,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cfg_we,
   input  logic [ADDR_W-1:0] cfg_addr,
   input  logic [1:0]        cfg_data,
   input  logic              start,
   input  logic [ADDR_W:0]   len,
   input  logic [LOOP_W-1:0] loops,
   output logic              fsm_reset,
   output logic [1:0]        fsm_ain,
   input  logic              fsm_aout,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [CNT_W-1:0]  ones_count,
   output logic              final_out
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CLR   = 3'd1,
      RUN   = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam logic [ADDR_W:0]  DEPTH_L = (ADDR_W+1)'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_t              state_r;
   state_t              state_n;
   logic [1:0]          mem_r [DEPTH];
   logic [ADDR_W-1:0]   idx_r;
   logic [ADDR_W-1:0]   idx_n;
   logic [LOOP_W-1:0]   loop_r;
   logic [LOOP_W-1:0]   loop_n;
   logic [ADDR_W:0]     len_r;
   logic [LOOP_W-1:0]   loops_r;
   logic                first_r;
   logic [CNT_W-1:0]    ones_r;
   logic                final_r;
   logic                busy_r;
   logic                done_r;
   logic                err_r;
   logic [1:0]          ain_r;
   logic                start_ok_s;
   logic                accept_s;
   logic                last_sym_s;
   logic                last_loop_s;
   logic                sample_s;
   logic                cfg_ok_s;

   // Next-state, run indexing and sampling qualifiers
   always_comb begin
      state_n     = state_r;
      idx_n       = idx_r;
      loop_n      = loop_r;
      start_ok_s  = (len != {(ADDR_W+1){1'b0}}) && (len <= DEPTH_L) &&
                    (loops != {LOOP_W{1'b0}});
      accept_s    = (state_r == IDLE) && start && start_ok_s;
      last_sym_s  = ({1'b0, idx_r} == (len_r - (ADDR_W+1)'(1'b1)));
      last_loop_s = (loop_r == (loops_r - LOOP_W'(1'b1)));
      // RUN cycle 0 still shows the detector's reset state, so it is skipped
      sample_s    = ((state_r == RUN) && !first_r) || (state_r == DRAIN);
      cfg_ok_s    = cfg_we && ((state_r == IDLE) || (state_r == DONE));
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               state_n = CLR;
            end else begin
               state_n = IDLE;
            end
         end
         CLR: begin
            state_n = RUN;
            idx_n   = {ADDR_W{1'b0}};
            loop_n  = {LOOP_W{1'b0}};
         end
         RUN: begin
            if (last_sym_s) begin
               idx_n = {ADDR_W{1'b0}};
               if (last_loop_s) begin
                  state_n = DRAIN;
               end else begin
                  loop_n = loop_r + LOOP_W'(1'b1);
               end
            end else begin
               idx_n = idx_r + ADDR_W'(1'b1);
            end
         end
         DRAIN:   state_n = DONE;
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // State register and run counters
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
         idx_r   <= {ADDR_W{1'b0}};
         loop_r  <= {LOOP_W{1'b0}};
         first_r <= 1'b0;
      end else begin
         state_r <= state_n;
         idx_r   <= idx_n;
         loop_r  <= loop_n;
         first_r <= (state_r == CLR);
      end
   end

   // Registered control outputs, decoded from the next state
   always_ff @(posedge clk) begin
      if (reset) begin
         busy_r <= 1'b0;
         done_r <= 1'b0;
         err_r  <= 1'b0;
         ain_r  <= 2'b00;
      end else begin
         busy_r <= (state_n == CLR) || (state_n == RUN) || (state_n == DRAIN);
         done_r <= (state_n == DONE);
         err_r  <= (state_r == IDLE) && start && !start_ok_s;
         ain_r  <= (state_n == RUN) ? mem_r[idx_n] : 2'b00;
      end
   end

   // Run parameters latched on an accepted start
   always_ff @(posedge clk) begin
      if (reset) begin
         len_r   <= {(ADDR_W+1){1'b0}};
         loops_r <= {LOOP_W{1'b0}};
      end else if (accept_s) begin
         len_r   <= len;
         loops_r <= loops;
      end
   end

   // Result accumulation: saturating ones counter and final aout
   always_ff @(posedge clk) begin
      if (reset) begin
         ones_r  <= {CNT_W{1'b0}};
         final_r <= 1'b0;
      end else if (accept_s) begin
         ones_r  <= {CNT_W{1'b0}};
         final_r <= 1'b0;
      end else begin
         if (sample_s && fsm_aout && (ones_r != CNT_MAX)) begin
            ones_r <= ones_r + CNT_W'(1'b1);
         end
         if (state_r == DRAIN) begin
            final_r <= fsm_aout;
         end
      end
   end

   // Pattern memory; writes are blocked while a run is in progress
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= 2'b00;
         end
      end else if (cfg_ok_s) begin
         mem_r[cfg_addr] <= cfg_data;
      end
   end

   // The detector shares the block reset so a mid-run reset clears it too
   assign fsm_reset  = reset | (state_r == CLR);
   assign fsm_ain    = ain_r;
   assign busy       = busy_r;
   assign done       = done_r;
   assign err        = err_r;
   assign ones_count = ones_r;
   assign final_out  = final_r;

endmodule

// File: tb/tb_moore_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_moore_seq_ctrl
// Self-checking bench for moore_seq_ctrl. Two instances (CNT_W=8 and CNT_W=3)
// share all stimulus, and each drives a behavioural detector. Expected results
// are computed by walking the symbol stream through the detector rules.
// -----------------------------------------------------------------------------
module tb_moore_seq_ctrl;
   localparam int DEPTH  = 8;
   localparam int ADDR_W = 3;
   localparam int LOOP_W = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic              cfg_we;
   logic [ADDR_W-1:0] cfg_addr;
   logic [1:0]        cfg_data;
   logic              start;
   logic [ADDR_W:0]   len;
   logic [LOOP_W-1:0] loops;
   logic              fsm_reset, fsm_reset3;
   logic [1:0]        fsm_ain, fsm_ain3;
   logic              fsm_aout, fsm_aout3;
   logic              busy, busy3, done, done3, err, err3;
   logic [7:0]        ones_count;
   logic [2:0]        ones_count3;
   logic              final_out, final_out3;
   logic              det_a, det_b;

   int checks = 0;
   int errors = 0;
   int last_ones = 0;
   logic [1:0] pat_m [DEPTH];

   always #5 clk = ~clk;

   moore_seq_ctrl #(.DEPTH(DEPTH), .LOOP_W(LOOP_W), .CNT_W(8)) dut (
      .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
      .cfg_data(cfg_data), .start(start), .len(len), .loops(loops),
      .fsm_reset(fsm_reset), .fsm_ain(fsm_ain), .fsm_aout(fsm_aout),
      .busy(busy), .done(done), .err(err), .ones_count(ones_count),
      .final_out(final_out));

   moore_seq_ctrl #(.DEPTH(DEPTH), .LOOP_W(LOOP_W), .CNT_W(3)) dut3 (
      .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
      .cfg_data(cfg_data), .start(start), .len(len), .loops(loops),
      .fsm_reset(fsm_reset3), .fsm_ain(fsm_ain3), .fsm_aout(fsm_aout3),
      .busy(busy3), .done(done3), .err(err3), .ones_count(ones_count3),
      .final_out(final_out3));

   // Detector rule: state0 -> 1 on 10/11; state1 -> 0 on 01/10
   function automatic logic det_next(input logic s, input logic [1:0] a);
      if (!s) return a[1];
      return !((a == 2'b01) || (a == 2'b10));
   endfunction

   always @(posedge clk) det_a <= fsm_reset  ? 1'b0 : det_next(det_a, fsm_ain);
   always @(posedge clk) det_b <= fsm_reset3 ? 1'b0 : det_next(det_b, fsm_ain3);
   assign fsm_aout  = det_a;
   assign fsm_aout3 = det_b;

   // Expected results: walk len*loops symbols from a cleared detector
   task automatic ref_run(input int l, input int lp, input int maxc,
                          output int ones, output int fin);
      logic s;
      s = 1'b0;
      ones = 0;
      for (int k = 0; k < l * lp; k++) begin
         s = det_next(s, pat_m[k % l]);
         if (s && ones < maxc) ones++;
      end
      fin = int'(s);
   endtask

   task automatic cfg_write(input int a, input logic [1:0] d);
      @(negedge clk);
      cfg_we = 1'b1; cfg_addr = ADDR_W'(a); cfg_data = d;
      pat_m[a] = d;
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   task automatic run_and_check(input string name, input int l, input int lp);
      int n, e_ones, e_fin, e_ones3, e_fin3, done_c, bad_busy, bad_rst;
      n = l * lp; done_c = 0; bad_busy = 0; bad_rst = 0;
      ref_run(l, lp, 255, e_ones, e_fin);
      ref_run(l, lp, 7, e_ones3, e_fin3);
      @(negedge clk);
      start = 1'b1; len = (ADDR_W+1)'(l); loops = LOOP_W'(lp);
      for (int c = 1; c <= n + 10 && done_c == 0; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (busy !== (c <= n + 2)) bad_busy++;
         if (fsm_reset !== (c == 1)) bad_rst++;
         if (done === 1'b1) done_c = c;
      end
      checks++;
      if (done_c != n + 3) begin
         errors++; $display("FAIL %s done_cycle got %0d want %0d", name, done_c, n + 3);
      end
      checks++;
      if (bad_busy != 0) begin
         errors++; $display("FAIL %s busy_window bad_cycles %0d want 0", name, bad_busy);
      end
      checks++;
      if (bad_rst != 0) begin
         errors++; $display("FAIL %s fsm_reset_window bad_cycles %0d want 0", name, bad_rst);
      end
      checks++;
      if (ones_count !== 8'(e_ones)) begin
         errors++; $display("FAIL %s ones_count got %0d want %0d", name, ones_count, e_ones);
      end
      checks++;
      if (final_out !== 1'(e_fin)) begin
         errors++; $display("FAIL %s final_out got %0b want %0d", name, final_out, e_fin);
      end
      checks++;
      if (ones_count3 !== 3'(e_ones3)) begin
         errors++; $display("FAIL %s ones_count_sat got %0d want %0d", name, ones_count3, e_ones3);
      end
      checks++;
      if (final_out3 !== 1'(e_fin3)) begin
         errors++; $display("FAIL %s final_out_sat got %0b want %0d", name, final_out3, e_fin3);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL %s done_pulse done %0b busy %0b want 0 0", name, done, busy);
      end
      last_ones = e_ones;
   endtask

   task automatic test_reset();
      reset = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = 2'b00;
      start = 1'b0; len = '0; loops = '0;
      for (int i = 0; i < DEPTH; i++) pat_m[i] = 2'b00;
      repeat (3) @(negedge clk);
      checks++;
      if ({busy, done, err, final_out, fsm_reset} !== 5'b00001 || ones_count !== 8'd0 ||
          fsm_ain !== 2'b00) begin
         errors++;
         $display("FAIL reset_state busy %0b done %0b err %0b fin %0b frst %0b ones %0d ain %0b want 0 0 0 0 1 0 00",
                  busy, done, err, final_out, fsm_reset, ones_count, fsm_ain);
      end
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (fsm_reset !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL reset_release fsm_reset %0b busy %0b want 0 0", fsm_reset, busy);
      end
      last_ones = 0;
      // Memory was cleared by reset: a full-depth run sees only 00 symbols
      run_and_check("cleared_memory", DEPTH, 1);
   endtask

   task automatic test_directed();
      cfg_write(0, 2'b10); cfg_write(1, 2'b00); cfg_write(2, 2'b01); cfg_write(3, 2'b11);
      run_and_check("pattern4_once", 4, 1);
      cfg_write(0, 2'b11);
      run_and_check("single_sym_loops5", 1, 5);
      cfg_write(0, 2'b10); cfg_write(1, 2'b10);
      run_and_check("toggle_loops3", 2, 3);
      cfg_write(0, 2'b11);
      run_and_check("saturation", 1, 10);
   endtask

   task automatic test_invalid_start();
      int bl[3];
      int blp[3];
      bl  = '{0, DEPTH + 1, 4};
      blp = '{1, 1, 0};
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         start = 1'b1; len = (ADDR_W+1)'(bl[i]); loops = LOOP_W'(blp[i]);
         @(negedge clk);
         start = 1'b0;
         checks++;
         if (err !== 1'b1 || busy !== 1'b0 || fsm_reset !== 1'b0) begin
            errors++;
            $display("FAIL invalid_start_%0d err %0b busy %0b frst %0b want 1 0 0", i, err, busy, fsm_reset);
         end
         @(negedge clk);
         checks++;
         if (err !== 1'b0 || busy !== 1'b0 || ones_count !== 8'(last_ones)) begin
            errors++;
            $display("FAIL invalid_after_%0d err %0b busy %0b ones %0d want 0 0 %0d",
                     i, err, busy, ones_count, last_ones);
         end
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 6; it++) begin
         for (int a = 0; a < DEPTH; a++) cfg_write(a, 2'($urandom_range(0, 3)));
         run_and_check($sformatf("random_%0d", it), int'($urandom_range(1, DEPTH)),
                       int'($urandom_range(1, 15)));
      end
   endtask

   task automatic test_midrun();
      int e_ones, e_fin, done_c;
      cfg_write(0, 2'b10); cfg_write(1, 2'b00); cfg_write(2, 2'b01); cfg_write(3, 2'b11);
      ref_run(4, 2, 255, e_ones, e_fin);
      done_c = 0;
      @(negedge clk);
      start = 1'b1; len = 4'd4; loops = 4'd2;
      for (int c = 1; c <= 20 && done_c == 0; c++) begin
         @(negedge clk);
         start = 1'b0; cfg_we = 1'b0;
         if (c == 2) begin
            cfg_we = 1'b1; cfg_addr = 3'd1; cfg_data = 2'b11; start = 1'b1;
         end
         if (done === 1'b1) done_c = c;
      end
      cfg_we = 1'b0;
      checks++;
      if (done_c != 11 || ones_count !== 8'(e_ones) || final_out !== 1'(e_fin)) begin
         errors++;
         $display("FAIL busy_ignore done_cycle %0d ones %0d fin %0b want 11 %0d %0d",
                  done_c, ones_count, final_out, e_ones, e_fin);
      end
      run_and_check("pattern_unchanged", 4, 2);
      // Reset lands in RUN cycle 2 (overall cycle 4)
      @(negedge clk);
      start = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         start = 1'b0;
      end
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || ones_count !== 8'd0 || fsm_ain !== 2'b00 || done !== 1'b0 ||
          final_out !== 1'b0 || fsm_reset !== 1'b1) begin
         errors++;
         $display("FAIL midrun_reset busy %0b ones %0d ain %0b done %0b fin %0b frst %0b want 0 0 00 0 0 1",
                  busy, ones_count, fsm_ain, done, final_out, fsm_reset);
      end
      reset = 1'b0;
      for (int i = 0; i < DEPTH; i++) pat_m[i] = 2'b00;
      cfg_write(0, 2'b10); cfg_write(1, 2'b00); cfg_write(2, 2'b01); cfg_write(3, 2'b11);
      run_and_check("fresh_after_reset", 4, 2);
   endtask

   initial begin
      test_reset();
      test_directed();
      test_invalid_start();
      test_random();
      test_midrun();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
